// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operation/result handshake bundle between control unit and alu_seq
//
// Signals (master = issuing control unit, slave = alu_seq):
//   in_valid, in_ready      operation offer / accept handshake
//   op, alu_src             operation code and operand-B select
//   rs1_data, rs2_data, imm operands (B taken from imm when alu_src=1)
//   out_valid, out_ready    result hold / consume handshake
//   result, eq, lt, ltu     registered result and compare flags

interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic            alu_src;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            eq;
  logic            lt;
  logic            ltu;

  modport master (
    output in_valid, op, alu_src, rs1_data, rs2_data, imm, out_ready,
    input  in_ready, out_valid, result, eq, lt, ltu
  );

  modport slave (
    input  in_valid, op, alu_src, rs1_data, rs2_data, imm, out_ready,
    output in_ready, out_valid, result, eq, lt, ltu
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle RV32I/RV32M execute-stage ALU with valid/ready handshake
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset
//   flush  synchronous abort of any operation in flight or result held
//   bus    alu_seq_if.slave: in_valid/in_ready, op, alu_src, rs1_data, rs2_data,
//          imm, out_valid/out_ready, result, eq, lt, ltu

module alu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  alu_seq_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD = 5'h00, OP_SUB = 5'h01, OP_AND = 5'h02, OP_OR = 5'h03,
                         OP_XOR = 5'h04, OP_SLT = 5'h05, OP_SLTU = 5'h06, OP_SLL = 5'h07,
                         OP_SRL = 5'h08, OP_SRA = 5'h09, OP_PASSB = 5'h0A,
                         OP_MUL = 5'h10, OP_MULH = 5'h11, OP_MULHSU = 5'h12,
                         OP_DIV = 5'h14, OP_REM = 5'h16;

  typedef enum logic [2:0] {S_IDLE, S_ALU, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d;

  function automatic logic a_signed(input logic [4:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(input logic [4:0] op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic s);
    return (s && x[XLEN-1]) ? -x : x;
  endfunction

  function automatic logic [XLEN-1:0] alu_single(input logic [4:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic [SHW-1:0]  sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_SLT:   r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:  r = {{(XLEN-1){1'b0}}, a < b};
      OP_SLL:   r = a << sh;
      OP_SRL:   r = a >> sh;
      OP_SRA:   r = $unsigned($signed(a) >>> sh);
      OP_PASSB: r = b;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Incoming operation decode (used only on the accept cycle)
  logic [XLEN-1:0] b_in;
  logic            accept, is_mul_in, is_div_in, div_by0, div_ovf;
  logic [XLEN-1:0] early_res;

  assign b_in      = bus.alu_src ? bus.imm : bus.rs2_data;
  assign accept    = bus.in_valid && (state_q == S_IDLE);
  assign is_mul_in = (bus.op[4:2] == 3'b100);
  assign is_div_in = (bus.op[4:2] == 3'b101);
  assign div_by0   = (b_in == '0);
  assign div_ovf   = a_signed(bus.op) && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (&b_in);
  // op[1] selects remainder (REM/REMU) over quotient (DIV/DIVU)
  assign early_res = div_by0 ? (bus.op[1] ? bus.rs1_data : '1)
                             : (bus.op[1] ? '0 : bus.rs1_data);

  // Iteration datapath on captured operands
  logic            sa, sb;
  logic [XLEN-1:0] ma, mb;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] acc_mul, acc_div, prod;
  logic [XLEN-1:0] quo, rem, fix_res;

  assign sa = a_signed(op_q) && a_q[XLEN-1];
  assign sb = b_signed(op_q) && b_q[XLEN-1];
  assign ma = mag(a_q, a_signed(op_q));
  assign mb = mag(b_q, b_signed(op_q));

  // Multiply: acc = {partial high, remaining multiplier bits}; add on LSB then shift right.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, ma} : '0);
  assign acc_mul = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}; quotient bits shift in at LSB.
  assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_sh - {1'b0, mb};
  assign acc_div  = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  assign prod    = (sa ^ sb) ? -acc_q : acc_q;
  assign quo     = (sa ^ sb) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem     = sa ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign fix_res = op_q[2] ? (op_q[1] ? rem : quo)
                           : ((op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    ltu_d    = ltu_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = bus.op;
          a_d   = bus.rs1_data;
          b_d   = b_in;
          eq_d  = (bus.rs1_data == b_in);
          lt_d  = ($signed(bus.rs1_data) < $signed(b_in));
          ltu_d = (bus.rs1_data < b_in);
          cnt_d = '0;
          if (is_mul_in) begin
            acc_d   = {{XLEN{1'b0}}, mag(b_in, b_signed(bus.op))};
            state_d = S_MUL;
          end else if (is_div_in && (div_by0 || div_ovf)) begin
            result_d = early_res;
            state_d  = S_DONE;
          end else if (is_div_in) begin
            acc_d   = {{XLEN{1'b0}}, mag(bus.rs1_data, a_signed(bus.op))};
            state_d = S_DIV;
          end else begin
            state_d = S_ALU;
          end
        end
      end
      S_ALU: begin
        result_d = alu_single(op_q, a_q, b_q);
        state_d  = S_DONE;
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_MUL) ? acc_mul : acc_div;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      ltu_q    <= ltu_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && rst_n;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;
  assign bus.ltu       = ltu_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed scoreboard bench for alu_seq at XLEN=32 and XLEN=16

module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  alu_seq_if #(.XLEN(32)) bus32 ();
  alu_seq_if #(.XLEN(16)) bus16 ();

  alu_seq #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32.slave));
  alu_seq #(.XLEN(16)) dut16 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus16.slave));

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [31:0] flg;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags32(input logic [31:0] a, input logic [31:0] b);
    return {29'd0, a == b, $signed(a) < $signed(b), a < b};
  endfunction

  function automatic logic [31:0] flags16(input logic [15:0] a, input logic [15:0] b);
    return {29'd0, a == b, $signed(a) < $signed(b), a < b};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run32(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic src, input logic [31:0] exp_res,
                       input int exp_lat, input int hold);
    exp_t e;
    int   lat;
    e.tag = tag; e.res = exp_res; e.flg = flags32(a, b); e.lat = exp_lat;
    sb_q.push_back(e);
    bus32.op        = op;
    bus32.rs1_data  = a;
    bus32.alu_src   = src;
    bus32.rs2_data  = src ? ~b : b;
    bus32.imm       = src ? b : ~b;
    bus32.out_ready = (hold == 0);
    chk({tag, " in_ready"}, 32'(bus32.in_ready), 32'd1);
    bus32.in_valid = 1'b1;
    tick();
    bus32.in_valid = 1'b0;
    lat = 1;
    while (!bus32.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    e = sb_q.pop_front();
    chk({e.tag, " result"}, bus32.result, e.res);
    chk({e.tag, " flags"}, {29'd0, bus32.eq, bus32.lt, bus32.ltu}, e.flg);
    chk({e.tag, " latency"}, 32'(lat), 32'(e.lat));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({e.tag, " stall result"}, bus32.result, e.res);
      chk({e.tag, " stall out_valid"}, 32'(bus32.out_valid), 32'd1);
      chk({e.tag, " stall in_ready"}, 32'(bus32.in_ready), 32'd0);
    end
    bus32.out_ready = 1'b1;
    tick();
    chk({e.tag, " out_valid drop"}, 32'(bus32.out_valid), 32'd0);
  endtask

  task automatic run16(input string tag, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_res, input int exp_lat);
    exp_t e;
    int   lat;
    e.tag = tag; e.res = {16'd0, exp_res}; e.flg = flags16(a, b); e.lat = exp_lat;
    sb_q.push_back(e);
    bus16.op        = op;
    bus16.rs1_data  = a;
    bus16.alu_src   = 1'b1;
    bus16.imm       = b;
    bus16.rs2_data  = ~b;
    bus16.out_ready = 1'b1;
    bus16.in_valid  = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    lat = 1;
    while (!bus16.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    e = sb_q.pop_front();
    chk({e.tag, " result"}, {16'd0, bus16.result}, e.res);
    chk({e.tag, " flags"}, {29'd0, bus16.eq, bus16.lt, bus16.ltu}, e.flg);
    chk({e.tag, " latency"}, 32'(lat), 32'(e.lat));
    tick();
    chk({e.tag, " out_valid drop"}, 32'(bus16.out_valid), 32'd0);
  endtask

  initial begin
    int highs;
    rst_n = 1'b0;
    flush = 1'b0;
    bus32.in_valid = 1'b0; bus32.op = '0; bus32.alu_src = 1'b0;
    bus32.rs1_data = '0; bus32.rs2_data = '0; bus32.imm = '0; bus32.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.op = '0; bus16.alu_src = 1'b0;
    bus16.rs1_data = '0; bus16.rs2_data = '0; bus16.imm = '0; bus16.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(bus32.in_ready), 32'd0);
    chk("reset out_valid", 32'(bus32.out_valid), 32'd0);
    chk("reset result", bus32.result, 32'd0);
    chk("reset flags", {29'd0, bus32.eq, bus32.lt, bus32.ltu}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("release in_ready", 32'(bus32.in_ready), 32'd1);

    run32("add_imm", 5'h00, 32'd5, 32'hFFFF_FFFD, 1'b1, 32'd2, 2, 0);
    run32("sra",     5'h09, 32'h8000_0000, 32'd4, 1'b0, 32'hF800_0000, 2, 0);
    run32("sltu",    5'h06, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd1, 2, 0);
    run32("sub_eq",  5'h01, 32'd7, 32'd7, 1'b0, 32'd0, 2, 0);
    run32("slt",     5'h05, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1, 2, 0);
    run32("sll_mask", 5'h07, 32'd1, 32'h0000_002F, 1'b0, 32'h0000_8000, 2, 0);
    run32("srl",     5'h08, 32'h8000_0000, 32'd31, 1'b0, 32'd1, 2, 0);
    run32("and",     5'h02, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 32'h0000_F000, 2, 0);
    run32("or",      5'h03, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 32'h0000_FFF0, 2, 0);
    run32("xor",     5'h04, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 32'h0000_0FF0, 2, 0);
    run32("passb",   5'h0A, 32'h0000_0123, 32'hABCD_E000, 1'b1, 32'hABCD_E000, 2, 0);
    run32("undef0b", 5'h0B, 32'd5, 32'd6, 1'b0, 32'd0, 2, 0);
    run32("undef18", 5'h18, 32'd5, 32'd6, 1'b0, 32'd0, 2, 0);

    run32("mulh",    5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 34, 0);
    run32("mulhu",   5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 34, 0);
    run32("mul",     5'h10, 32'h1234_5678, 32'h10, 1'b0, 32'h2345_6780, 34, 0);
    run32("mulhsu",  5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 34, 0);
    run32("mul_neg", 5'h10, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'hFFFF_FFF1, 34, 0);

    run32("div",     5'h14, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 34, 0);
    run32("rem",     5'h16, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 34, 0);
    run32("div_nd",  5'h14, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 34, 0);
    run32("rem_nd",  5'h16, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1, 34, 0);
    run32("divu",    5'h15, 32'd100, 32'd7, 1'b0, 32'd14, 34, 0);
    run32("remu",    5'h17, 32'd100, 32'd7, 1'b0, 32'd2, 34, 0);
    run32("divu_by0", 5'h15, 32'd7, 32'd0, 1'b0, 32'hFFFF_FFFF, 1, 0);
    run32("rem_by0", 5'h16, 32'd7, 32'd0, 1'b0, 32'd7, 1, 0);
    run32("div_ovf", 5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1, 0);
    run32("rem_ovf", 5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 1, 0);

    run32("stall_add", 5'h00, 32'd10, 32'd20, 1'b0, 32'd30, 2, 10);

    // Abort a DIV during its fifth iteration.
    bus32.op = 5'h14; bus32.rs1_data = 32'd1000; bus32.rs2_data = 32'd3; bus32.alu_src = 1'b0;
    bus32.in_valid = 1'b1;
    tick();
    bus32.in_valid = 1'b0;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush out_valid", 32'(bus32.out_valid), 32'd0);
    chk("flush in_ready", 32'(bus32.in_ready), 32'd1);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus32.out_valid) highs++;
    end
    chk("flush no out_valid", 32'(highs), 32'd0);
    run32("add_after_flush", 5'h00, 32'd40, 32'd2, 1'b0, 32'd42, 2, 0);

    run16("w16_add",   5'h00, 16'd5, 16'hFFFD, 16'd2, 2);
    run16("w16_mulhu", 5'h13, 16'hFFFF, 16'hFFFF, 16'hFFFE, 18);
    run16("w16_mul",   5'h10, 16'h1234, 16'h0010, 16'h2340, 18);
    run16("w16_mulh",  5'h11, 16'hFFFF, 16'hFFFF, 16'h0000, 18);
    run16("w16_div",   5'h14, 16'hFFF9, 16'd2, 16'hFFFD, 18);
    run16("w16_rem",   5'h16, 16'hFFF9, 16'd2, 16'hFFFF, 18);
    run16("w16_ovf",   5'h14, 16'h8000, 16'hFFFF, 16'h8000, 1);
    run16("w16_rem0",  5'h16, 16'd7, 16'd0, 16'd7, 1);

    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
